// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
// Parity support is built only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the accepted word, shifts it out LSB-first and tracks which data bit is on the line.
// o_lastBit flags that the most significant data bit is currently being sent.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_first,
    output logic                  o_bit,
    output logic                  o_lastBit,
    output logic                  o_wordXor
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_idx;

    // The shift register always presents the next bit to emit at position 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold  <= '0;
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_hold  <= i_data;
            r_shift <= i_data;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> 1;
            r_idx   <= i_first ? '0 : r_idx + 1'b1;
        end
    end

    assign o_bit     = r_shift[0];
    assign o_lastBit = (r_idx == CNT_W'(DATA_WIDTH - 1));
    assign o_wordXor = ^r_hold;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: frame FSM plus registered TX line, one bit per baud tick.
// Define UART_TX_PARITY_EN to build the optional parity bit (PAR_EN/PAR_TYP are ignored otherwise).
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_2,
    output logic                  TX_OUT,
    output logic                  busy
);

    import uart_tx_pkg::*;

    state_t r_state;
    state_t w_nextState;
    logic   r_txOut;
    logic   w_txNext;
    logic   r_stop2;
    logic   r_stopCnt;
    logic   w_stopNext;
    logic   w_load;
    logic   w_shift;
    logic   w_first;
    logic   w_bit;
    logic   w_lastBit;
    logic   w_wordXor;

`ifdef UART_TX_PARITY_EN
    logic r_parEn;
    logic r_parTyp;
    logic w_parityBit;

    assign w_parityBit = (r_parTyp == PAR_ODD) ? ~w_wordXor : w_wordXor;
`else
    logic w_unusedSink;

    assign w_unusedSink = ^{PAR_EN, PAR_TYP, w_wordXor};
`endif

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_load    (w_load),
        .i_data    (P_DATA),
        .i_shift   (w_shift),
        .i_first   (w_first),
        .o_bit     (w_bit),
        .o_lastBit (w_lastBit),
        .o_wordXor (w_wordXor)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_txOut   <= 1'b1;
            r_stop2   <= uart_tx_pkg::STOP_1;
            r_stopCnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parEn   <= 1'b0;
            r_parTyp  <= PAR_EVEN;
`endif
        end else begin
            r_state   <= w_nextState;
            r_txOut   <= w_txNext;
            r_stopCnt <= w_stopNext;
            if (w_load) begin
                r_stop2  <= STOP_2;
`ifdef UART_TX_PARITY_EN
                r_parEn  <= PAR_EN;
                r_parTyp <= PAR_TYP;
`endif
            end
        end
    end

    // Every line change below is gated by tick, so each bit spans one baud period.
    always_comb begin
        w_nextState = r_state;
        w_txNext    = r_txOut;
        w_stopNext  = r_stopCnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_first     = 1'b0;
        case (r_state)
            IDLE: begin
                w_txNext = 1'b1;
                if (Data_Valid) begin
                    w_load      = 1'b1;
                    w_nextState = ARMED;
                end
            end
            ARMED: begin
                if (tick) begin
                    w_nextState = START;
                    w_txNext    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    w_nextState = DATA;
                    w_txNext    = w_bit;
                    w_shift     = 1'b1;
                    w_first     = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (!w_lastBit) begin
                        w_txNext = w_bit;
                        w_shift  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    end else if (r_parEn) begin
                        w_nextState = PARITY;
                        w_txNext    = w_parityBit;
`endif
                    end else begin
                        w_nextState = STOP;
                        w_txNext    = 1'b1;
                        w_stopNext  = 1'b0;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    w_nextState = STOP;
                    w_txNext    = 1'b1;
                    w_stopNext  = 1'b0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    w_txNext = 1'b1;
                    if ((r_stop2 == uart_tx_pkg::STOP_2) && !r_stopCnt) begin
                        w_stopNext = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                        w_stopNext  = 1'b0;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_txNext    = 1'b1;
            end
        endcase
    end

    assign TX_OUT = r_txOut;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: an 8-bit and a 5-bit instance share stimulus and are
// compared every cycle against a frame-list model; directed frames are pinned to literal patterns.
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic       tick;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP_2;
    logic       txOut8, busy8, txOut5, busy5;

    int checks = 0;
    int errors = 0;

    int tickPeriod = 4;
    int tickCnt    = 0;

    // Model state: the full expected frame per instance and how many ticks have passed since acceptance.
    int   wid [2] = '{8, 5};
    bit   frm [2][0:31];
    int   flen [2];
    bit   mBusy [2];
    bit   mLine [2];
    int   mTick [2];
    bit   armed = 1'b0;
    logic [1:0] unusedCfg;

    uart_tx_core #(.DATA_WIDTH(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_2(STOP_2), .TX_OUT(txOut8), .busy(busy8)
    );

    uart_tx_core #(.DATA_WIDTH(5)) u_dut5 (
        .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA[4:0]), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_2(STOP_2), .TX_OUT(txOut5), .busy(busy5)
    );

    always #5 CLK = ~CLK;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge CLK);
            tickCnt++;
            if (tickCnt >= tickPeriod) begin
                tick    = 1'b1;
                tickCnt = 0;
            end else begin
                tick = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void buildFrame(int k, logic [7:0] d, logic pe, logic pt, logic s2);
        int n    = 0;
        int ones = 0;
        frm[k][n] = 1'b0;
        n++;
        for (int i = 0; i < wid[k]; i++) begin
            frm[k][n] = d[i];
            ones += int'(d[i]);
            n++;
        end
`ifdef UART_TX_PARITY_EN
        if (pe) begin
            frm[k][n] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
`else
        unusedCfg = {pe, pt};
`endif
        frm[k][n] = 1'b1;
        n++;
        if (s2) begin
            frm[k][n] = 1'b1;
            n++;
        end
        flen[k] = n;
    endfunction

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                mBusy[k] = 1'b0;
                mLine[k] = 1'b1;
                mTick[k] = 0;
                armed    = 1'b1;
            end else if (!mBusy[k]) begin
                mLine[k] = 1'b1;
                if (Data_Valid) begin
                    buildFrame(k, P_DATA, PAR_EN, PAR_TYP, STOP_2);
                    mBusy[k] = 1'b1;
                    mTick[k] = 0;
                end
            end else if (tick) begin
                mTick[k]++;
                if (mTick[k] <= flen[k]) begin
                    mLine[k] = frm[k][mTick[k] - 1];
                end else begin
                    mBusy[k] = 1'b0;
                    mLine[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            check("line8", txOut8, mLine[0]);
            check("busy8", busy8, mBusy[0]);
            check("line5", txOut5, mLine[1]);
            check("busy5", busy5, mBusy[1]);
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP_2     = s2;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    // Records line and busy of both instances after each of the next n tick edges.
    task automatic checkOutput(input int n, output logic [31:0] l8, output logic [31:0] b8,
                               output logic [31:0] l5, output logic [31:0] b5);
        int   got = 0;
        int   cyc = 0;
        logic t;
        l8 = '0; b8 = '0; l5 = '0; b5 = '0;
        while (got < n && cyc < 2000) begin
            @(posedge CLK);
            t = tick;
            @(negedge CLK);
            cyc++;
            if (t) begin
                l8[got] = txOut8;
                b8[got] = busy8;
                l5[got] = txOut5;
                b5[got] = busy5;
                got++;
            end
        end
        if (got < n) check("tickTimeout", 32'(got), 32'(n));
    endtask

    task automatic waitIdle();
        int c = 0;
        while ((mBusy[0] || mBusy[1]) && c < 3000) begin
            @(negedge CLK);
            c++;
        end
        if (c >= 3000) check("idleTimeout", 32'(c), 32'd0);
    endtask

    task automatic waitBusy8Fall();
        int c = 0;
        while (busy8 !== 1'b0 && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        if (c >= 2000) check("fallTimeout", 32'(c), 32'd0);
    endtask

    logic [31:0] l8, b8, l5, b5;

    initial begin
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP_2 = 1'b0;
        repeat (3) @(negedge CLK);
        check("rstLine8", txOut8, 1'b1);
        check("rstBusy8", busy8, 1'b0);
        check("rstLine5", txOut5, 1'b1);
        check("rstBusy5", busy5, 1'b0);
        RST = 1'b0;

        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput(11, l8, b8, l5, b5);
`ifdef UART_TX_PARITY_EN
        check("a5Line", l8[10:0], 11'h54A);
        check("a5Busy", b8[10:0], 11'h7FF);
`else
        check("a5Line", l8[10:0], 11'h74A);
        check("a5Busy", b8[10:0], 11'h3FF);
`endif
        waitIdle();

        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
        checkOutput(10, l8, b8, l5, b5);
`ifdef UART_TX_PARITY_EN
        check("odd01Parity", l8[9], 1'b0);
`else
        check("odd01Stop", l8[9], 1'b1);
`endif
        waitIdle();

        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput(10, l8, b8, l5, b5);
        check("odd00Bit9", l8[9], 1'b1);
        waitIdle();

        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        checkOutput(12, l8, b8, l5, b5);
        check("ffLine", l8[11:0], 12'hFFE);
        check("ffBusy", b8[11:0], 12'h7FF);
        waitIdle();

        applyStimulus(8'h13, 1'b1, 1'b0, 1'b0);
        checkOutput(9, l8, b8, l5, b5);
        check("w5Line", l5[8:0], 9'h1E6);
`ifdef UART_TX_PARITY_EN
        check("w5Busy", b5[8:0], 9'h0FF);
`else
        check("w5Busy", b5[8:0], 9'h07F);
`endif
        waitIdle();

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        checkOutput(3, l8, b8, l5, b5);
        @(negedge CLK);
        P_DATA     = 8'h3C;
        Data_Valid = 1'b1;
        waitBusy8Fall();
        Data_Valid = 1'b0;
        repeat (6) @(negedge CLK);
        check("ignoredStrobe", busy8, 1'b0);
        waitIdle();

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        waitBusy8Fall();
        P_DATA     = 8'h3C;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        check("acceptAfterFall", busy8, 1'b1);
        waitIdle();

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        checkOutput(5, l8, b8, l5, b5);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midRstLine", txOut8, 1'b1);
        check("midRstBusy", busy8, 1'b0);
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b0);
        checkOutput(11, l8, b8, l5, b5);
        check("x96Line", l8[10:0], 11'h72C);
        waitIdle();

        for (int n = 0; n < 40; n++) begin
            int c;
            waitIdle();
            tickPeriod = $urandom_range(1, 6);
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            c = 0;
            while (mBusy[0] && c < 600) begin
                @(negedge CLK);
                c++;
                Data_Valid = ($urandom_range(0, 7) == 0);
                P_DATA     = 8'($urandom);
                PAR_EN     = 1'($urandom);
                PAR_TYP    = 1'($urandom);
                STOP_2     = 1'($urandom);
                RST        = ($urandom_range(0, 199) == 0);
            end
            Data_Valid = 1'b0;
            RST        = 1'b0;
            if (c >= 600) check("randTimeout", 32'(c), 32'd0);
        end
        waitIdle();
        repeat (4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
